// File: rtl/arith_pkg.sv
// Shared definitions for the adder/subtractor family of leaf datapath blocks.
package arith_pkg;

    localparam int unsigned DEC_WIDTH_DEFAULT = 4;

    typedef logic [DEC_WIDTH_DEFAULT-1:0] dec_word_t;

endpackage

// File: rtl/dec_core.sv
// Combinational decrement-by-one: ripple-borrow chain with optional saturation at zero.
module dec_core
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH    = DEC_WIDTH_DEFAULT,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] d,
    output logic             b
);

    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff;

    // Subtracting one is a borrow injected at bit 0; it ripples up while bits are zero.
    always_comb begin
        br    = '0;
        diff  = '0;
        br[0] = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            diff[i]  = inp[i] ^ br[i];
            br[i+1]  = br[i] & ~inp[i];
        end
    end

    // Borrow out of the top stage means every bit was zero.
    assign b = br[WIDTH];

    always_comb begin
        d = diff;
        if (SATURATE && b) begin
            d = '0;
        end
    end

endmodule

// File: rtl/decrementor.sv
// Registered unsigned decrement-by-one with borrow and zero flags; one-cycle latency.
module decrementor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH    = DEC_WIDTH_DEFAULT,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] o,
    output logic             borrow,
    output logic             zero
);

    logic [WIDTH-1:0] d;
    logic             b;

    dec_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .inp (inp),
        .d   (d),
        .b   (b)
    );

    // Reset state is a consistent "result of zero": o=0 with zero flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o      <= '0;
            borrow <= 1'b0;
            zero   <= 1'b1;
        end else begin
            o      <= d;
            borrow <= b;
            zero   <= (d == '0);
        end
    end

endmodule

// File: tb/tb_decrementor.sv
// Directed self-checking bench for decrementor in wrap, saturate and 8-bit configurations.
module tb_decrementor;

    logic       clk;
    logic       rst_n;
    logic [3:0] inp4, inp4s;
    logic [7:0] inp8;
    logic [3:0] o4, o4s;
    logic [7:0] o8;
    logic       borrow4, borrow4s, borrow8;
    logic       zero4, zero4s, zero8;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        int unsigned sel;
        logic [7:0]  o;
        logic        b;
        logic        z;
    } exp_t;

    exp_t sb[$];

    decrementor #(.WIDTH(4), .SATURATE(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .inp(inp4), .o(o4), .borrow(borrow4), .zero(zero4)
    );
    decrementor #(.WIDTH(4), .SATURATE(1'b1)) dut4s (
        .clk(clk), .rst_n(rst_n), .inp(inp4s), .o(o4s), .borrow(borrow4s), .zero(zero4s)
    );
    decrementor #(.WIDTH(8), .SATURATE(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .inp(inp8), .o(o8), .borrow(borrow8), .zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0 = WIDTH 4 wrap, 1 = WIDTH 4 saturate, 2 = WIDTH 8 wrap
    function automatic exp_t model(int unsigned sel, int unsigned val);
        exp_t        e;
        int unsigned w;
        int unsigned mask;
        w    = (sel == 2) ? 8 : 4;
        mask = (1 << w) - 1;
        e.sel = sel;
        if (val == 0) e.o = (sel == 1) ? 8'd0 : 8'(mask);
        else          e.o = 8'(val - 1);
        e.b = (val == 0);
        e.z = (e.o == 8'd0);
        return e;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(int unsigned sel, int unsigned val);
        case (sel)
            0:       inp4  = 4'(val);
            1:       inp4s = 4'(val);
            default: inp8  = 8'(val);
        endcase
        sb.push_back(model(sel, val));
    endtask

    task automatic check_next(string tag);
        exp_t       e;
        logic [7:0] oo;
        logic       ob, oz;
        n_asserts++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       begin oo = {4'd0, o4};  ob = borrow4;  oz = zero4;  end
                1:       begin oo = {4'd0, o4s}; ob = borrow4s; oz = zero4s; end
                default: begin oo = o8;          ob = borrow8;  oz = zero8;  end
            endcase
            chk({tag, "_o"}, oo, e.o);
            chk({tag, "_borrow"}, {7'd0, ob}, {7'd0, e.b});
            chk({tag, "_zero"}, {7'd0, oz}, {7'd0, e.z});
        end
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_o4"}, {4'd0, o4}, 8'd0);
        chk({tag, "_borrow4"}, {7'd0, borrow4}, 8'd0);
        chk({tag, "_zero4"}, {7'd0, zero4}, 8'd1);
        chk({tag, "_o8"}, o8, 8'd0);
        chk({tag, "_zero8"}, {7'd0, zero8}, 8'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        inp4  = 4'd9;
        inp4s = 4'd9;
        inp8  = 8'd9;

        // Reset asserted before any clock edge must take effect immediately.
        #2 rst_n = 1'b0;
        #1 check_reset("rst_async");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset("rst_hold");
        end

        // Release between edges; the first edge afterwards gives 9-1.
        #3 rst_n = 1'b1;
        drive(0, 9);
        drive(1, 9);
        drive(2, 9);
        tick();
        check_next("rst_rel4");
        check_next("rst_rel4s");
        check_next("rst_rel8");

        for (int unsigned v = 0; v < 16; v++) begin
            drive(0, v);
            tick();
            check_next("sweep");
        end

        begin
            int unsigned wrap_seq [5] = '{2, 1, 0, 0, 15};
            foreach (wrap_seq[k]) begin
                drive(0, wrap_seq[k]);
                tick();
                check_next("wrap");
            end
        end

        drive(1, 0);
        tick();
        check_next("sat_zero");
        drive(1, 5);
        tick();
        check_next("sat_five");
        drive(1, 1);
        tick();
        check_next("sat_one");

        drive(2, 0);
        tick();
        check_next("w8_zero");
        drive(2, 128);
        tick();
        check_next("w8_128");
        drive(2, 255);
        tick();
        check_next("w8_255");

        // Mid-stream reset between edges drops o without waiting for a clock.
        drive(0, 8);
        tick();
        check_next("pre_mid");
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        drive(0, 3);
        #2 rst_n = 1'b1;
        tick();
        check_next("post_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
